// File: rtl/nibble_serial_subtractor_pkg.sv
// rtl/nibble_serial_subtractor_pkg.sv - shared state encoding and nibble width
package nibble_serial_subtractor_pkg;
   localparam int NIBBLE_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY,
      DONE = ST_DONE
   } state_t;
endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// rtl/nibble_serial_subtractor_if.sv - operand/result handshake bundle
interface nibble_serial_subtractor_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_diff;
   logic             out_borrow;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_diff, out_borrow
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_diff, out_borrow
   );
endinterface

// File: rtl/nibble_serial_subtractor_cla.sv
// rtl/nibble_serial_subtractor_cla.sv - 4-bit carry-lookahead adder slice
module cla_sub_slice
   import nibble_serial_subtractor_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);
   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // every carry is expanded directly from cin, no ripple between bits
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = p ^ c;
endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - serial a-b, one nibble per cycle, LSB first
// SUB_SATURATE_EN: clamp the difference to zero when a borrow occurs.
module nibble_serial_subtractor
   import nibble_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   nibble_serial_subtractor_if.slave bus
);
   localparam int N     = WIDTH / NIBBLE_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_t                state;
   state_t                next_state;
   logic [CNT_W-1:0]      cnt;
   logic [WIDTH-1:0]      a_sh;
   logic [WIDTH-1:0]      nb_sh;
   logic [WIDTH-1:0]      work;
   logic [WIDTH-1:0]      diff_r;
   logic                  borrow_r;
   logic                  carry;
   logic [NIBBLE_W-1:0]   sum;
   logic                  cout;
   logic [WIDTH+NIBBLE_W-1:0] work_cat;
   logic [WIDTH-1:0]      work_next;
   logic                  accept;
   logic                  last;

   cla_sub_slice u_slice (
      .a    (a_sh[NIBBLE_W-1:0]),
      .b    (nb_sh[NIBBLE_W-1:0]),
      .cin  (carry),
      .s    (sum),
      .cout (cout)
   );

   assign accept    = bus.in_valid && (state == IDLE);
   assign last      = (cnt == CNT_W'(N - 1));
   assign work_cat  = {sum, work};
   assign work_next = work_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.in_valid) next_state = BUSY;
         BUSY:    if (last) next_state = DONE;
         DONE:    if (bus.out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // result registers only change on the final nibble, so they hold through IDLE/BUSY
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         carry    <= 1'b0;
         a_sh     <= '0;
         nb_sh    <= '0;
         work     <= '0;
         diff_r   <= '0;
         borrow_r <= 1'b0;
      end else if (accept) begin
         a_sh  <= bus.in_a;
         nb_sh <= ~bus.in_b;
         carry <= 1'b1;
         cnt   <= '0;
      end else if (state == BUSY) begin
         a_sh  <= a_sh >> NIBBLE_W;
         nb_sh <= nb_sh >> NIBBLE_W;
         work  <= work_next;
         carry <= cout;
         cnt   <= cnt + CNT_W'(1);
         if (last) begin
            borrow_r <= ~cout;
`ifdef SUB_SATURATE_EN
            diff_r   <= cout ? work_next : '0;
`else
            diff_r   <= work_next;
`endif
         end
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.out_diff   = diff_r;
   assign bus.out_borrow = borrow_r;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - directed and random checks of the serial subtractor
module tb_nibble_serial_subtractor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   nibble_serial_subtractor_if #(.WIDTH(16)) bus ();

   nibble_serial_subtractor #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic op_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_diff, input logic exp_borrow);
      int cyc;
      send(a, b);
      wait_done(cyc);
      check({tag, "_lat"}, cyc, 4);
      check({tag, "_diff"}, bus.out_diff, exp_diff);
      check({tag, "_borrow"}, bus.out_borrow, exp_borrow);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] sat_diff(input logic [16:0] r);
`ifdef SUB_SATURATE_EN
      return r[16] ? 16'h0000 : r[15:0];
`else
      return r[15:0];
`endif
   endfunction

   initial begin
      int cyc;
      logic [15:0] ra, rb;
      logic [16:0] ref_r;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_diff", bus.out_diff, 0);
      check("rst_borrow", bus.out_borrow, 0);
      rst = 1'b0;

      op_check("t1", 16'h1234, 16'h0034, 16'h1200, 1'b0);
`ifdef SUB_SATURATE_EN
      op_check("t2", 16'h0000, 16'h0001, 16'h0000, 1'b1);
`else
      op_check("t2", 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
`endif
      op_check("t3_eq", 16'hABCD, 16'hABCD, 16'h0000, 1'b0);
      op_check("t3_max", 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);

      // backpressure: result must hold while the consumer stalls
      bus.out_ready = 1'b0;
      send(16'h8000, 16'h0001);
      wait_done(cyc);
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", bus.out_valid, 1);
         check("bp_diff", bus.out_diff, 16'h7FFF);
         check("bp_in_ready", bus.in_ready, 0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      check("bp_in_ready_same", bus.in_ready, 0);
      @(posedge clk);
      #1;
      check("bp_in_ready_after", bus.in_ready, 1);
      check("bp_diff_hold", bus.out_diff, 16'h7FFF);

      // busy lockout: in_valid stays high with new operands every cycle
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h5555;
      bus.in_b     = 16'h1111;
      @(posedge clk);
      #1;
      cyc = 0;
      while (!bus.out_valid && cyc < 50) begin
         bus.in_a = bus.in_a + 16'h0101;
         bus.in_b = 16'hFFFF - bus.in_b;
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      check("lock_diff", bus.out_diff, 16'h4444);
      check("lock_borrow", bus.out_borrow, 0);
      @(posedge clk);
      #1;

      // reset on the second BUSY cycle
      send(16'h00F0, 16'h000F);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_diff", bus.out_diff, 0);
      op_check("t6", 16'h00F0, 16'h000F, 16'h00E1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         ref_r = {1'b0, ra} - {1'b0, rb};
         op_check("rand", ra, rb, sat_diff(ref_r), ref_r[16]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
